fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the five-stage MIPS pipeline. It replaces the single-cycle program counter, PC+4 adder and direct instruction-memory lookup with a decoupled fetch stage. The stage has a request/response interface to instruction memory, an in-order fetch queue of configurable depth, decode backpressure, and branch/jump redirect with squash of in-flight fetches. It sits between instruction memory and the IF/ID boundary.

---
 rtl/fetch_unit_pkg.sv | 14 +
 rtl/fetch_queue.sv | 61 ++++++
 rtl/fetch_unit.sv | 103 ++++++++++
 tb/tb_fetch_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package fetch_unit_pkg;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP              = 32'h0000_0000;
   localparam logic [31:0] INSTR_BYTES      = 32'd4;

   // One fetch-queue entry: the instruction word and the address it came from.
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue: DEPTH entries of {instr, pc}, flushable in one cycle.
// Head data is read straight out of the storage registers.
module fetch_queue
   import fetch_unit_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               push,
   input  fetch_entry_t       push_data,
   input  logic               pop,
   input  logic               flush,
   output fetch_entry_t       head_data,
   output logic [CNT_W-1:0]   count,
   output logic               full,
   output logic               empty
);

   localparam int PTR_W = $clog2(DEPTH);

   fetch_entry_t     storage [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty && !flush;
   // A push into a full queue is only taken when the head leaves the same cycle.
   assign do_push = push && !flush && (!full || do_pop);

   // Pointer and occupancy update; flush empties the queue in one edge.
   always_ff @(posedge clock) begin
      if (!reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // One write-enabled register per slot; pointers wrap naturally because DEPTH is a power of two.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clock) begin
         if (do_push && (wr_ptr == PTR_W'(gi))) storage[gi] <= push_data;
      end
   end

   // Present the head entry, or a NOP with pc 0 while empty.
   always_comb begin
      head_data = storage[rd_ptr];
      if (empty) head_data = '{instr: NOP, pc: 32'h0};
   end

endmodule

// File: rtl/fetch_unit.sv
// Decoupled fetch stage: credit-limited requests to instruction memory,
// in-order fetch queue towards decode, and redirect with squash of stale responses.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [31:0] instr_pc_plus_four
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [31:0]      fetch_pc;
   logic [31:0]      resp_pc;
   logic [31:0]      redirect_target;
   logic [CNT_W-1:0] inflight;
   logic [CNT_W-1:0] drop;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;
   logic             req_fire;
   logic             push;
   logic             pop;
   fetch_entry_t     head;
   fetch_entry_t     push_entry;

   assign redirect_target = redirect_pc & ~32'h3;

   // Credit: every outstanding request owns a queue slot, so a response can always be stored.
   // full is implied by the sum test and is kept as a cheap guard.
   assign imem_req  = !redirect_valid && !full &&
                      (({1'b0, count} + {1'b0, inflight}) < (CNT_W + 1)'(DEPTH));
   assign imem_addr = fetch_pc;
   assign req_fire  = imem_req && imem_ready;

   assign instr_valid = !empty && !redirect_valid;
   assign pop         = instr_valid && instr_ready;
   assign push        = imem_rvalid && (drop == '0) && !redirect_valid;
   assign push_entry  = '{instr: imem_rdata, pc: resp_pc};

   assign instr              = head.instr;
   assign instr_pc           = head.pc;
   assign instr_pc_plus_four = head.pc + INSTR_BYTES;

   // Next fetch address: redirect wins, otherwise advance on each accepted request.
   always_ff @(posedge clock) begin
      if (!reset)              fetch_pc <= RESET_PC;
      else if (redirect_valid) fetch_pc <= redirect_target;
      else if (req_fire)       fetch_pc <= fetch_pc + INSTR_BYTES;
   end

   // Address of the next kept response; responses return in request order.
   always_ff @(posedge clock) begin
      if (!reset)              resp_pc <= RESET_PC;
      else if (redirect_valid) resp_pc <= redirect_target;
      else if (push)           resp_pc <= resp_pc + INSTR_BYTES;
   end

   // Outstanding-request and stale-response counters. inflight already includes
   // responses owed for earlier redirects, so on a redirect every request still
   // outstanding after this edge becomes stale.
   always_ff @(posedge clock) begin
      if (!reset) begin
         inflight <= '0;
         drop     <= '0;
      end else begin
         inflight <= inflight + CNT_W'(req_fire) - CNT_W'(imem_rvalid);
         if (redirect_valid)                    drop <= inflight - CNT_W'(imem_rvalid);
         else if (imem_rvalid && (drop != '0))  drop <= drop - 1'b1;
      end
   end

   fetch_queue #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_queue (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .flush     (redirect_valid),
      .head_data (head),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised scoreboard bench for fetch_unit with an in-order memory model.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] instr_pc_plus_four;

   fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clock              (clock),
      .reset              (reset),
      .imem_req           (imem_req),
      .imem_addr          (imem_addr),
      .imem_ready         (imem_ready),
      .imem_rvalid        (imem_rvalid),
      .imem_rdata         (imem_rdata),
      .redirect_valid     (redirect_valid),
      .redirect_pc        (redirect_pc),
      .instr_valid        (instr_valid),
      .instr_ready        (instr_ready),
      .instr              (instr),
      .instr_pc           (instr_pc),
      .instr_pc_plus_four (instr_pc_plus_four)
   );

   always #5 clock = ~clock;

   // Outstanding memory request and expected queue entry.
   typedef struct { logic [31:0] addr; bit stale; int due; } req_t;
   typedef struct { logic [31:0] instr; logic [31:0] pc; } exp_t;

   req_t        pend[$];
   exp_t        exp_q[$];
   logic [31:0] model_pc = RESET_PC;
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   int          n_deliv = 0;

   int          ready_pct = 100;
   int          iready_pct = 100;
   int          redir_pm = 0;
   int          lat_min = 1;
   int          lat_max = 1;
   bit          hold_reset = 1'b1;
   bit          force_redir = 1'b0;
   logic [31:0] force_pc = 32'h0;

   // Contents of instruction memory: a fixed scramble of the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Monitor: per-cycle interface checks and scoreboard pop on each delivery.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         #1;
         if (reset) begin
            check("instr_valid", {31'b0, instr_valid},
                  {31'b0, (exp_q.size() != 0) && !redirect_valid});
            check("imem_req", {31'b0, imem_req},
                  {31'b0, ((exp_q.size() + pend.size()) < DEPTH) && !redirect_valid});
            check("imem_addr", imem_addr, model_pc);
            if (instr_valid && instr_ready && exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("instr", instr, e.instr);
               check("instr_pc", instr_pc, e.pc);
               check("instr_pc_plus_four", instr_pc_plus_four, e.pc + 32'd4);
               n_deliv++;
               $display("cycle %0d deliver pc=%h instr=%h", cyc, instr_pc, instr);
            end
         end
      end
   end

   // Drive one cycle of stimulus, then update the memory model and expected queue.
   task automatic run_cycle();
      req_t r;
      int   sel;
      @(posedge clock);
      #1;
      cyc++;
      reset      = !hold_reset;
      imem_ready = ($urandom_range(99) < ready_pct);
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_word(pend[0].addr);
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
      end
      redirect_valid = !hold_reset && (force_redir || ($urandom_range(999) < redir_pm));
      sel = $urandom_range(3);
      if (force_redir)   redirect_pc = force_pc;
      else if (sel == 0) redirect_pc = 32'hFFFF_FFF9;
      else               redirect_pc = $urandom & 32'h0000_0FFF;
      instr_ready = ($urandom_range(99) < iready_pct);

      @(negedge clock);
      #2;
      if (!reset) begin
         pend.delete();
         exp_q.delete();
         model_pc = RESET_PC;
      end else begin
         assert (!imem_rvalid || pend.size() > 0)
            else $error("FAIL protocol: response with nothing in flight");
         if (imem_rvalid && pend.size() > 0) begin
            r = pend.pop_front();
            if (!r.stale && !redirect_valid) exp_q.push_back('{mem_word(r.addr), r.addr});
         end
         if (redirect_valid) begin
            foreach (pend[i]) pend[i].stale = 1'b1;
            exp_q.delete();
            model_pc = redirect_pc & ~32'h3;
            $display("cycle %0d redirect to %h", cyc, model_pc);
         end else if (imem_req && imem_ready) begin
            pend.push_back('{imem_addr, 1'b0, cyc + int'($urandom_range(lat_max, lat_min))});
            model_pc = model_pc + 32'd4;
         end
      end
   endtask

   task automatic reset_pulse();
      hold_reset = 1'b1;
      run_cycle();
      hold_reset = 1'b0;
   endtask

   initial begin
      // Reset, then streaming with single-cycle memory and a free decoder.
      repeat (3) run_cycle();
      hold_reset = 1'b0;
      repeat (30) run_cycle();

      // Decode stalled from reset: credit caps requests at DEPTH, then drains in order.
      reset_pulse();
      iready_pct = 0;
      repeat (12) run_cycle();
      iready_pct = 100;
      repeat (20) run_cycle();

      // Latency 3 with a redirect to 0x100 while requests are in flight.
      lat_min = 3; lat_max = 3;
      repeat (6) run_cycle();
      force_redir = 1'b1; force_pc = 32'h0000_0100;
      run_cycle();
      force_redir = 1'b0;
      repeat (20) run_cycle();

      // Memory not ready for three cycles: the address must hold.
      lat_min = 1; lat_max = 1;
      force_redir = 1'b1; force_pc = 32'h0000_0020;
      run_cycle();
      force_redir = 1'b0;
      ready_pct = 0;
      repeat (3) run_cycle();
      ready_pct = 100;
      repeat (10) run_cycle();

      // Redirect to the top of the address space to exercise pc wrap.
      force_redir = 1'b1; force_pc = 32'hFFFF_FFF7;
      run_cycle();
      force_redir = 1'b0;
      repeat (10) run_cycle();

      // Fully random traffic, including redirects coinciding with responses and dequeues.
      ready_pct = 70; iready_pct = 60; redir_pm = 60; lat_min = 1; lat_max = 4;
      repeat (3000) run_cycle();

      // Fill the queue with requests in flight, then reset mid-stream.
      redir_pm = 0; ready_pct = 100; iready_pct = 0; lat_min = 3; lat_max = 3;
      repeat (4) run_cycle();
      reset_pulse();
      iready_pct = 100; lat_min = 1; lat_max = 1;
      repeat (20) run_cycle();

      n_cmp++;
      if (n_deliv < 100) begin
         n_err++;
         $display("FAIL deliveries: got %0d required at least 100", n_deliv);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
